// File: rtl/alu_muldiv_seq_if.sv
// Request/response and ALU-sharing bundle for alu_muldiv_seq.
// master: pipeline + shared ALU side; slave: the sequencer.
interface alu_muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            alu_sel;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [2:0]      alu_ctrl;
    logic [XLEN-1:0] alu_result;

    modport master (
        output start, op, opa, opb, alu_result,
        input  busy, done, result,
        input  alu_sel, alu_a, alu_b, alu_ctrl
    );

    modport slave (
        input  start, op, opa, opb, alu_result,
        output busy, done, result,
        output alu_sel, alu_a, alu_b, alu_ctrl
    );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU borrowing the execute ALU.
// Ports: clk, reset (async high), bus (slave: request, result, ALU mux).
module alu_muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset,
    alu_muldiv_seq_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e          state_q;
    logic [4:0]      cnt_q;
    logic [1:0]      op_q;
    // hi: H (mul) / R (div); lo: L (mul) / Q (div); opd: M / D
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] opd_q;
    logic [XLEN-1:0] result_q;
    logic            done_q;

    logic            is_mul;
    logic            busy;
    logic [XLEN:0]   t_w;
    logic            carry_w;
    logic            ge_w;
    logic [XLEN-1:0] hi_d;
    logic [XLEN-1:0] lo_d;
    logic [XLEN-1:0] fin_w;

    assign is_mul = ~op_q[1];
    assign busy   = (state_q == RUN);
    assign t_w    = {hi_q, lo_q[XLEN-1]};

    always_comb begin
        // ALU add overflowed iff the wrapped sum is below an addend
        carry_w = (bus.alu_result < hi_q);
        ge_w    = (t_w >= {1'b0, opd_q});
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (is_mul) begin
            if (lo_q[0]) begin
                {hi_d, lo_d} = {carry_w, bus.alu_result,
                                lo_q[XLEN-1:1]};
            end else begin
                {hi_d, lo_d} = {1'b0, hi_q, lo_q[XLEN-1:1]};
            end
        end else if (ge_w) begin
            hi_d = bus.alu_result;
            lo_d = {lo_q[XLEN-2:0], 1'b1};
        end else begin
            hi_d = t_w[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b0};
        end
        // MULHU/REMU read the high half, MUL/DIVU the low half
        fin_w = op_q[0] ? hi_d : lo_d;
    end

    assign bus.busy     = busy;
    assign bus.alu_sel  = busy;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.alu_a    = !busy ? '0
                        : (is_mul ? hi_q : t_w[XLEN-1:0]);
    assign bus.alu_b    = busy ? opd_q : '0;
    assign bus.alu_ctrl = (busy && !is_mul) ? 3'b001 : 3'b000;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opd_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                RUN: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q  <= DONE;
                        result_q <= fin_w;
                        done_q   <= 1'b1;
                    end
                end
                IDLE, DONE: begin
                    state_q <= IDLE;
                    if (bus.start) begin
                        op_q  <= bus.op;
                        cnt_q <= '0;
                        hi_q  <= '0;
                        lo_q  <= bus.op[1] ? bus.opa : bus.opb;
                        opd_q <= bus.op[1] ? bus.opb : bus.opa;
                        if (bus.op[1] && (bus.opb == '0)) begin
                            // divide by zero finishes without iterating
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                            result_q <= bus.op[0] ? bus.opa : '1;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq with a behavioural ALU
// and an arithmetic reference model.
module tb_alu_muldiv_seq;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    alu_muldiv_seq_if ifc ();

    alu_muldiv_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    // shared execute-stage ALU
    assign ifc.alu_result = (ifc.alu_ctrl == 3'b001)
                          ? ifc.alu_a - ifc.alu_b
                          : ifc.alu_a + ifc.alu_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_res(
        input logic [1:0] op,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (op)
            2'd0: return p[31:0];
            2'd1: return p[63:32];
            2'd2: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(
        input logic [1:0] op,
        input logic [31:0] b
    );
        return (op[1] && b == 0) ? 1 : 33;
    endfunction

    task automatic issue(
        input logic [1:0] op,
        input logic [31:0] a,
        input logic [31:0] b
    );
        @(negedge clk);
        ifc.start = 1'b1;
        ifc.op    = op;
        ifc.opa   = a;
        ifc.opb   = b;
        @(posedge clk);
        #1 ifc.start = 1'b0;
    endtask

    // Observe one operation cycle by cycle after its accept edge.
    task automatic wait_done(
        input int p1,
        input int p2,
        input bit chain,
        input logic [1:0] cop,
        input logic [31:0] ca,
        input logic [31:0] cb,
        output logic [31:0] res,
        output int bcnt,
        output int dcyc,
        output int serr
    );
        bcnt = 0;
        dcyc = 0;
        serr = 0;
        res  = 'x;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (ifc.busy === 1'b1) bcnt++;
            if (ifc.alu_sel !== ifc.busy) serr++;
            if (ifc.busy !== 1'b1 &&
                (ifc.alu_a !== 0 || ifc.alu_b !== 0 ||
                 ifc.alu_ctrl !== 0)) serr++;
            if (k == p1 || k == p2) begin
                ifc.start = 1'b1;
                ifc.op    = 2'($urandom);
                ifc.opa   = $urandom;
                ifc.opb   = $urandom;
            end
            if (ifc.done === 1'b1) begin
                dcyc = k;
                res  = ifc.result;
                if (chain) begin
                    ifc.start = 1'b1;
                    ifc.op    = cop;
                    ifc.opa   = ca;
                    ifc.opb   = cb;
                end
                @(posedge clk);
                #1 ifc.start = 1'b0;
                break;
            end
            @(posedge clk);
            #1 ifc.start = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        ifc.start = 1'b0;
        ifc.op    = '0;
        ifc.opa   = '0;
        ifc.opb   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks += 7;
        if (ifc.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_busy: got %b want 0", ifc.busy);
        end
        if (ifc.done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_done: got %b want 0", ifc.done);
        end
        if (ifc.result !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_result: got %h want 0", ifc.result);
        end
        if (ifc.alu_sel !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_sel: got %b want 0", ifc.alu_sel);
        end
        if (ifc.alu_a !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_alu_a: got %h want 0", ifc.alu_a);
        end
        if (ifc.alu_b !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_alu_b: got %h want 0", ifc.alu_b);
        end
        if (ifc.alu_ctrl !== 3'd0) begin
            n_fail++;
            $display("FAIL rst_ctrl: got %b want 0", ifc.alu_ctrl);
        end
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [1:0]  ops [10] = '{0, 1, 0, 1, 2, 3, 2, 3, 2, 3};
        logic [31:0] as  [10] = '{7, 7, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                  100, 100, 32'hFFFFFFFF, 5,
                                  32'h12345678, 32'h12345678};
        logic [31:0] bs  [10] = '{6, 6, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                  7, 7, 1, 9, 0, 0};
        logic [31:0] ex  [10] = '{32'h2A, 0, 1, 32'hFFFFFFFE,
                                  32'hE, 2, 32'hFFFFFFFF, 5,
                                  32'hFFFFFFFF, 32'h12345678};
        logic [31:0] res;
        int bc, dc, se, lat;
        for (int i = 0; i < 10; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_done(0, 0, 1'b0, 2'd0, 0, 0, res, bc, dc, se);
            lat = (i >= 8) ? 1 : 33;
            n_checks += 5;
            if (res !== ex[i]) begin
                n_fail++;
                $display("FAIL dir%0d_result: got %h want %h",
                         i, res, ex[i]);
            end
            if (dc !== lat) begin
                n_fail++;
                $display("FAIL dir%0d_done_cycle: got %0d want %0d",
                         i, dc, lat);
            end
            if (bc !== lat - 1) begin
                n_fail++;
                $display("FAIL dir%0d_busy_cycles: got %0d want %0d",
                         i, bc, lat - 1);
            end
            if (se !== 0) begin
                n_fail++;
                $display("FAIL dir%0d_alu_mux: got %0d errs want 0",
                         i, se);
            end
            @(negedge clk);
            if (ifc.done !== 1'b0 || ifc.result !== ex[i]) begin
                n_fail++;
                $display("FAIL dir%0d_hold: got done=%b res=%h want 0 %h",
                         i, ifc.done, ifc.result, ex[i]);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [31:0] res;
        int bc, dc, se;
        issue(2'd0, 32'hDEAD_BEEF, 32'h0000_1234);
        wait_done(5, 20, 1'b0, 2'd0, 0, 0, res, bc, dc, se);
        n_checks += 3;
        if (res !== ref_res(2'd0, 32'hDEAD_BEEF, 32'h1234)) begin
            n_fail++;
            $display("FAIL ign_result: got %h want %h", res,
                     ref_res(2'd0, 32'hDEAD_BEEF, 32'h1234));
        end
        if (dc !== 33) begin
            n_fail++;
            $display("FAIL ign_done_cycle: got %0d want 33", dc);
        end
        if (bc !== 32) begin
            n_fail++;
            $display("FAIL ign_busy_cycles: got %0d want 32", bc);
        end
        @(negedge clk);
        n_checks++;
        if (ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin
            n_fail++;
            $display("FAIL ign_no_queue: got busy=%b done=%b want 0 0",
                     ifc.busy, ifc.done);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        int bc, dc, se;
        issue(2'd0, 32'h1234, 32'h5678);
        wait_done(0, 0, 1'b1, 2'd2, 1000, 7, res, bc, dc, se);
        n_checks += 2;
        if (res !== 32'h0626_0060) begin
            n_fail++;
            $display("FAIL b2b_first: got %h want 06260060", res);
        end
        if (dc !== 33) begin
            n_fail++;
            $display("FAIL b2b_first_cycle: got %0d want 33", dc);
        end
        wait_done(0, 0, 1'b0, 2'd0, 0, 0, res, bc, dc, se);
        n_checks += 3;
        if (res !== 32'd142) begin
            n_fail++;
            $display("FAIL b2b_second: got %h want 0000008e", res);
        end
        if (dc !== 33) begin
            n_fail++;
            $display("FAIL b2b_second_cycle: got %0d want 33", dc);
        end
        if (bc !== 32) begin
            n_fail++;
            $display("FAIL b2b_second_busy: got %0d want 32", bc);
        end
    endtask

    task automatic test_abort();
        logic [31:0] res;
        int bc, dc, se, seen;
        issue(2'd0, 3, 3);
        wait_done(0, 0, 1'b0, 2'd0, 0, 0, res, bc, dc, se);
        n_checks++;
        if (res !== 32'd9) begin
            n_fail++;
            $display("FAIL abort_pre: got %h want 9", res);
        end
        issue(2'd2, 32'h8765_4321, 3);
        repeat (10) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (ifc.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_busy_before: got %b want 1", ifc.busy);
        end
        #1 reset = 1'b1;
        #1;
        n_checks += 4;
        if (ifc.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_busy: got %b want 0", ifc.busy);
        end
        if (ifc.done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_done: got %b want 0", ifc.done);
        end
        if (ifc.alu_sel !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_sel: got %b want 0", ifc.alu_sel);
        end
        if (ifc.result !== 32'd0) begin
            n_fail++;
            $display("FAIL abort_result: got %h want 0", ifc.result);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ifc.done !== 1'b0 || ifc.busy !== 1'b0) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL abort_quiet: got %0d active cycles want 0",
                     seen);
        end
        issue(2'd0, 3, 5);
        wait_done(0, 0, 1'b0, 2'd0, 0, 0, res, bc, dc, se);
        n_checks += 2;
        if (res !== 32'd15) begin
            n_fail++;
            $display("FAIL abort_post: got %h want f", res);
        end
        if (dc !== 33) begin
            n_fail++;
            $display("FAIL abort_post_cycle: got %0d want 33", dc);
        end
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a, b, res, exp;
        int bc, dc, se, lat, sel;
        for (int i = 0; i < 24; i++) begin
            op  = 2'($urandom_range(0, 3));
            a   = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0: b = 0;
                1: b = $urandom_range(1, 15);
                2: b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            exp = ref_res(op, a, b);
            lat = ref_lat(op, b);
            issue(op, a, b);
            wait_done(0, 0, 1'b0, 2'd0, 0, 0, res, bc, dc, se);
            n_checks += 3;
            if (res !== exp) begin
                n_fail++;
                $display("FAIL rnd%0d op%0d %h,%h: got %h want %h",
                         i, op, a, b, res, exp);
            end
            if (dc !== lat || bc !== lat - 1) begin
                n_fail++;
                $display("FAIL rnd%0d_timing: got %0d/%0d want %0d/%0d",
                         i, dc, bc, lat, lat - 1);
            end
            if (se !== 0) begin
                n_fail++;
                $display("FAIL rnd%0d_alu_mux: got %0d errs want 0",
                         i, se);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
